// File: rtl/jtcontra_snd_romarb.sv
// rtl/jtcontra_snd_romarb.sv - sound CPU / ADPCM ROM sharing of one SDRAM slot (optional JTCONTRA_SNDARB_CPUPRIO_EN)
//
// Each requester keeps a one-byte read cache. Hits are answered
// combinationally from the registered entry. Misses are funnelled into a
// single cs/ok transaction toward the SDRAM slot. With
// JTCONTRA_SNDARB_CPUPRIO_EN defined, simultaneous misses always go to the
// CPU. Otherwise they alternate through a round-robin pointer.

module jtcontra_snd_romarb #(
    parameter int                 CPU_AW     = 15,
    parameter int                 PCM_AW     = 17,
    parameter int                 SLOT_AW    = 18,
    parameter logic [SLOT_AW-1:0] PCM_OFFSET = 18'h08000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_cs,
    input  logic [CPU_AW-1:0]  cpu_addr,
    output logic [7:0]         cpu_data,
    output logic               cpu_ok,
    input  logic               pcm_cs,
    input  logic [PCM_AW-1:0]  pcm_addr,
    output logic [7:0]         pcm_data,
    output logic               pcm_ok,
    output logic               slot_cs,
    output logic [SLOT_AW-1:0] slot_addr,
    input  logic [7:0]         slot_data,
    input  logic               slot_ok,
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Cache entries
    logic              cpu_valid;
    logic [CPU_AW-1:0] cpu_tag;
    logic [7:0]        cpu_byte;
    logic              pcm_valid;
    logic [PCM_AW-1:0] pcm_tag;
    logic [7:0]        pcm_byte;

    // Outstanding request bookkeeping
    logic               owner_pcm;
    logic               req_first;
    logic [CPU_AW-1:0]  cpu_req_addr;
    logic [PCM_AW-1:0]  pcm_req_addr;
    logic [SLOT_AW-1:0] slot_addr_r;

    logic cpu_hit;
    logic pcm_hit;
    logic cpu_miss;
    logic pcm_miss;
    logic grant_pcm;
    logic start;
    logic capture;

    logic [SLOT_AW-1:0] cpu_slot_addr;
    logic [SLOT_AW-1:0] pcm_slot_addr;

`ifndef JTCONTRA_SNDARB_CPUPRIO_EN
    logic favour_pcm;
`endif

    assign cpu_hit  = cpu_cs && cpu_valid && (cpu_addr == cpu_tag);
    assign pcm_hit  = pcm_cs && pcm_valid && (pcm_addr == pcm_tag);
    assign cpu_miss = cpu_cs && !cpu_hit;
    assign pcm_miss = pcm_cs && !pcm_hit;

    // The CPU region starts at slot address 0; the ADPCM region is offset and wraps
    assign cpu_slot_addr = SLOT_AW'(cpu_addr);
    assign pcm_slot_addr = PCM_OFFSET + SLOT_AW'(pcm_addr);

`ifdef JTCONTRA_SNDARB_CPUPRIO_EN
    assign grant_pcm = pcm_miss && !cpu_miss;
`else
    assign grant_pcm = pcm_miss && (!cpu_miss || favour_pcm);
`endif

    assign start   = (state == IDLE) && (cpu_miss || pcm_miss);
    // The first REQ cycle may see an ok left over from a previous access
    assign capture = (state == REQ) && !req_first && slot_ok;

    assign cpu_ok    = cpu_hit;
    assign pcm_ok    = pcm_hit;
    assign cpu_data  = cpu_byte;
    assign pcm_data  = pcm_byte;
    assign slot_addr = slot_addr_r;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = REQ;
            REQ:     if (capture) state_nxt = GAP;
            GAP:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Slot handshake outputs decoded from state so reset drops them at once
    always_comb begin
        slot_cs = 1'b0;
        busy    = 1'b0;
        if (state == REQ) begin
            slot_cs = 1'b1;
            busy    = 1'b1;
        end
    end

    // Latch owner and address of the request being started
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_pcm    <= 1'b0;
            slot_addr_r  <= '0;
            cpu_req_addr <= '0;
            pcm_req_addr <= '0;
        end else if (start) begin
            owner_pcm <= grant_pcm;
            if (grant_pcm) begin
                slot_addr_r  <= pcm_slot_addr;
                pcm_req_addr <= pcm_addr;
            end else begin
                slot_addr_r  <= cpu_slot_addr;
                cpu_req_addr <= cpu_addr;
            end
        end
    end

    // Flag marking the first cycle of REQ
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_first <= 1'b0;
        end else begin
            req_first <= start;
        end
    end

    // CPU cache entry fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_valid <= 1'b0;
            cpu_tag   <= '0;
            cpu_byte  <= 8'd0;
        end else if (capture && !owner_pcm) begin
            cpu_valid <= 1'b1;
            cpu_tag   <= cpu_req_addr;
            cpu_byte  <= slot_data;
        end
    end

    // ADPCM cache entry fill
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcm_valid <= 1'b0;
            pcm_tag   <= '0;
            pcm_byte  <= 8'd0;
        end else if (capture && owner_pcm) begin
            pcm_valid <= 1'b1;
            pcm_tag   <= pcm_req_addr;
            pcm_byte  <= slot_data;
        end
    end

`ifndef JTCONTRA_SNDARB_CPUPRIO_EN
    // Round-robin pointer flips only when both requesters miss together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            favour_pcm <= 1'b0;
        end else if (start && cpu_miss && pcm_miss) begin
            favour_pcm <= ~favour_pcm;
        end
    end
`endif

endmodule

// File: tb/tb_jtcontra_snd_romarb.sv
// tb/tb_jtcontra_snd_romarb.sv - self-checking bench for jtcontra_snd_romarb
module tb_jtcontra_snd_romarb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cpu_cs;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_data;
    logic        cpu_ok;
    logic        pcm_cs;
    logic [16:0] pcm_addr;
    logic [7:0]  pcm_data;
    logic        pcm_ok;
    logic        slot_cs;
    logic [17:0] slot_addr;
    logic [7:0]  slot_data;
    logic        slot_ok;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // slot responder controls
    bit mode = 1'b0;      // 1: slot_ok held high permanently
    int lat = 3;
    bit rand_lat = 1'b0;

    // reference cache model
    logic        m_cpu_v, m_pcm_v;
    logic [14:0] m_cpu_tag;
    logic [16:0] m_pcm_tag;
    logic [7:0]  m_cpu_d, m_pcm_d;
    int          cs_age;

    jtcontra_snd_romarb dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_cs    (cpu_cs),
        .cpu_addr  (cpu_addr),
        .cpu_data  (cpu_data),
        .cpu_ok    (cpu_ok),
        .pcm_cs    (pcm_cs),
        .pcm_addr  (pcm_addr),
        .pcm_data  (pcm_data),
        .pcm_ok    (pcm_ok),
        .slot_cs   (slot_cs),
        .slot_addr (slot_addr),
        .slot_data (slot_data),
        .slot_ok   (slot_ok),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input logic [17:0] a);
        mem = a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h5A;
    endfunction

    function automatic logic [17:0] pmap(input logic [16:0] a);
        pmap = 18'h08000 + {1'b0, a};
    endfunction

    // SDRAM slot model: ok for one cycle, lat cycles after cs rises
    initial begin : responder
        bit prev_cs;
        int cyc;
        int cur_lat;
        prev_cs   = 1'b0;
        cyc       = 0;
        cur_lat   = 3;
        slot_ok   = 1'b0;
        slot_data = 8'd0;
        forever begin
            @(posedge clk);
            #2;
            if (!rst_n) begin
                slot_ok = 1'b0;
            end else if (mode) begin
                slot_ok   = 1'b1;
                slot_data = mem(slot_addr);
            end else begin
                if (slot_cs) begin
                    if (!prev_cs) begin
                        cyc     = 0;
                        cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
                    end else begin
                        cyc++;
                    end
                end
                slot_ok   = slot_cs && (cyc == cur_lat);
                slot_data = slot_ok ? mem(slot_addr) : 8'($urandom);
            end
            prev_cs = rst_n && slot_cs;
        end
    end

    // Cache model: an entry fills on any ok seen after the first cycle of a slot request
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cpu_v   <= 1'b0;
            m_pcm_v   <= 1'b0;
            m_cpu_tag <= '0;
            m_pcm_tag <= '0;
            m_cpu_d   <= 8'd0;
            m_pcm_d   <= 8'd0;
            cs_age    <= 0;
        end else begin
            cs_age <= slot_cs ? cs_age + 1 : 0;
            if (slot_cs && slot_ok && cs_age != 0) begin
                if (slot_addr < 18'h08000) begin
                    m_cpu_v   <= 1'b1;
                    m_cpu_tag <= slot_addr[14:0];
                    m_cpu_d   <= slot_data;
                end else begin
                    m_pcm_v   <= 1'b1;
                    m_pcm_tag <= 17'(slot_addr - 18'h08000);
                    m_pcm_d   <= slot_data;
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_cs(input string tag);
        int n;
        n = 0;
        while (slot_cs !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk(tag, slot_cs, 1);
    endtask

    task automatic wait_cs_low(input string tag);
        int n;
        n = 0;
        while (slot_cs !== 1'b0 && n < 20) begin
            step();
            n++;
        end
        chk(tag, slot_cs, 0);
    endtask

    task automatic wait_ok(input bit pcm, output int n);
        n = 0;
        while ((pcm ? pcm_ok : cpu_ok) !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        chk(pcm ? "pcm_ok_timeout" : "cpu_ok_timeout", pcm ? pcm_ok : cpu_ok, 1);
    endtask

    task automatic both_round(input logic [14:0] ca, input logic [16:0] pa, input bit pcm_first);
        int g;
        int n;
        cpu_cs   = 1'b1;
        pcm_cs   = 1'b1;
        cpu_addr = ca;
        pcm_addr = pa;
        #1;
        wait_cs("rr_first_cs");
        chk("rr_first_addr", slot_addr, pcm_first ? pmap(pa) : {3'd0, ca});
        wait_cs_low("rr_first_done");
        g = 0;
        while (slot_cs !== 1'b1 && g < 20) begin
            step();
            g++;
        end
        chk("rr_idle_gap", g, 2);
        chk("rr_second_addr", slot_addr, pcm_first ? {3'd0, ca} : pmap(pa));
        n = 0;
        while (!(cpu_ok && pcm_ok) && n < 30) begin
            step();
            n++;
        end
        chk("rr_both_ok", {cpu_ok, pcm_ok}, 2'b11);
        chk("rr_cpu_data", cpu_data, mem({3'd0, ca}));
        chk("rr_pcm_data", pcm_data, mem(pmap(pa)));
    endtask

    initial begin : stimulus
        int n;
        int cnt;
        bit exp_cpu_ok;
        bit exp_pcm_ok;

        rst_n    = 1'b0;
        cpu_cs   = 1'b0;
        cpu_addr = '0;
        pcm_cs   = 1'b0;
        pcm_addr = '0;

        // reset values
        step();
        step();
        chk("rst_slot_cs", slot_cs, 0);
        chk("rst_slot_addr", slot_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cpu_data", cpu_data, 0);
        chk("rst_pcm_data", pcm_data, 0);
        chk("rst_cpu_ok", cpu_ok, 0);
        chk("rst_pcm_ok", pcm_ok, 0);
        rst_n = 1'b1;
        step();

        // CPU miss, fill, then zero-latency hits
        cpu_cs   = 1'b1;
        cpu_addr = 15'h0123;
        #1;
        chk("t1_miss_ok", cpu_ok, 0);
        chk("t1_idle_cs", slot_cs, 0);
        step();
        chk("t1_req_cs", slot_cs, 1);
        chk("t1_req_busy", busy, 1);
        chk("t1_slot_addr", slot_addr, 18'h00123);
        wait_ok(1'b0, n);
        chk("t1_latency", n, 4);
        chk("t1_cpu_data", cpu_data, mem(18'h00123));
        chk("t1_gap_cs", slot_cs, 0);
        chk("t1_gap_busy", busy, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t1_hit_ok", cpu_ok, 1);
            chk("t1_hit_no_cs", slot_cs, 0);
        end
        cpu_cs = 1'b0;
        #1;
        chk("t1_cs_low_ok", cpu_ok, 0);
        chk("t1_cs_low_data", cpu_data, mem(18'h00123));

        // ADPCM top address mapped past the offset
        pcm_cs   = 1'b1;
        pcm_addr = 17'h1FFFF;
        #1;
        chk("t2_miss_ok", pcm_ok, 0);
        wait_cs("t2_cs");
        chk("t2_slot_addr", slot_addr, 18'h27FFF);
        wait_ok(1'b1, n);
        chk("t2_latency", n, 4);
        chk("t2_pcm_data", pcm_data, mem(18'h27FFF));
        pcm_cs = 1'b0;

        // simultaneous misses after reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        both_round(15'h0040, 17'h00040, 1'b0);
`ifdef JTCONTRA_SNDARB_CPUPRIO_EN
        both_round(15'h0041, 17'h00041, 1'b0);
`else
        both_round(15'h0041, 17'h00041, 1'b1);
`endif
        both_round(15'h0042, 17'h00042, 1'b0);

        // slot_ok held high before and through the request
        pcm_cs = 1'b0;
        mode   = 1'b1;
        step();
        step();
        chk("t4_idle_cs", slot_cs, 0);
        cpu_addr = 15'h7FFF;
        #1;
        wait_cs("t4_cs");
        chk("t4_slot_addr", slot_addr, 18'h07FFF);
        step();
        chk("t4_second_req_cs", slot_cs, 1);
        chk("t4_second_req_ok", cpu_ok, 0);
        step();
        chk("t4_gap_cs", slot_cs, 0);
        chk("t4_fill_ok", cpu_ok, 1);
        chk("t4_fill_data", cpu_data, mem(18'h07FFF));
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (slot_cs) cnt++;
        end
        chk("t4_single_capture", cnt, 0);
        mode = 1'b0;
        step();

        // address change mid-request, with a hit on the other requester
        pcm_cs   = 1'b1;
        pcm_addr = 17'h00042;
        cpu_addr = 15'h0010;
        #1;
        chk("t5_pcm_hit", pcm_ok, 1);
        wait_cs("t5_cs");
        chk("t5_slot_addr", slot_addr, 18'h00010);
        step();
        cpu_addr = 15'h0011;
        #1;
        chk("t5_new_addr_ok", cpu_ok, 0);
        chk("t5_nonowner_hit", pcm_ok, 1);
        chk("t5_addr_stable", slot_addr, 18'h00010);
        n = 0;
        while (slot_cs && n < 20) begin
            chk("t5_owner_ok_low", cpu_ok, 0);
            step();
            n++;
        end
        chk("t5_gap_cs", slot_cs, 0);
        chk("t5_gap_ok", cpu_ok, 0);
        cpu_addr = 15'h0010;
        #1;
        chk("t5_old_tag_ok", cpu_ok, 1);
        chk("t5_old_tag_data", cpu_data, mem(18'h00010));
        cpu_addr = 15'h0011;
        #1;
        chk("t5_new_tag_miss", cpu_ok, 0);
        wait_cs("t5_rereq_cs");
        chk("t5_rereq_addr", slot_addr, 18'h00011);
        wait_ok(1'b0, n);
        chk("t5_rereq_data", cpu_data, mem(18'h00011));

        // cs dropped mid-request: fill still completes
        cpu_addr = 15'h0020;
        #1;
        wait_cs("t5b_cs");
        cpu_cs = 1'b0;
        #1;
        wait_cs_low("t5b_done");
        cpu_cs = 1'b1;
        #1;
        chk("t5b_fill_ok", cpu_ok, 1);
        chk("t5b_fill_data", cpu_data, mem(18'h00020));
        step();
        chk("t5b_no_rereq", slot_cs, 0);

        // reset during a request
        cpu_addr = 15'h0030;
        #1;
        wait_cs("t6_cs");
        rst_n = 1'b0;
        #1;
        chk("t6_rst_cs", slot_cs, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ok", cpu_ok, 0);
        chk("t6_rst_data", cpu_data, 0);
        step();
        rst_n    = 1'b1;
        pcm_cs   = 1'b0;
        cpu_addr = 15'h0020;
        #1;
        chk("t6_cached_misses", cpu_ok, 0);
        wait_cs("t6_rereq_cs");
        chk("t6_rereq_addr", slot_addr, 18'h00020);
        wait_ok(1'b0, n);

        // randomized traffic against the cache model
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step();
            cpu_cs = ($urandom_range(0, 3) != 0);
            pcm_cs = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0)
                cpu_addr = ($urandom_range(0, 1) == 1) ? 15'h7FFC + 15'($urandom_range(0, 3))
                                                       : 15'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0)
                pcm_addr = ($urandom_range(0, 1) == 1) ? 17'h1FFFC + 17'($urandom_range(0, 3))
                                                       : 17'($urandom_range(0, 3));
            #1;
            exp_cpu_ok = cpu_cs && m_cpu_v && (cpu_addr == m_cpu_tag);
            exp_pcm_ok = pcm_cs && m_pcm_v && (pcm_addr == m_pcm_tag);
            chk("rnd_cpu_ok", cpu_ok, exp_cpu_ok);
            chk("rnd_pcm_ok", pcm_ok, exp_pcm_ok);
            chk("rnd_cpu_data", cpu_data, m_cpu_d);
            chk("rnd_pcm_data", pcm_data, m_pcm_d);
        end
        cpu_cs = 1'b1;
        pcm_cs = 1'b1;
        #1;
        n = 0;
        while (!(cpu_ok && pcm_ok) && n < 40) begin
            step();
            n++;
        end
        chk("rnd_final_ok", {cpu_ok, pcm_ok}, 2'b11);
        chk("rnd_final_cpu_data", cpu_data, mem({3'd0, cpu_addr}));
        chk("rnd_final_pcm_data", pcm_data, mem(pmap(pcm_addr)));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtcontra_snd_romarb.md
Name: jtcontra_snd_romarb

Overview:
- Shares one SDRAM ROM slot between the sound Z80 program ROM (32 kB) and the uPD7759 ADPCM sample ROM (128 kB).
- Sits between the sound subsystem (Z80 rom_cs/rom_addr and the ADPCM rom_cs/rom_addr) and the SDRAM slot controller.
- Keeps a one-entry read cache per requester, arbitrates misses round-robin and runs a cs/ok handshake toward the slot.
- Returns per-requester data and ok so the CPU wait logic and ADPCM DRQ logic work unchanged.

Parameters:
- CPU_AW, 15, CPU ROM byte-address width.
- PCM_AW, 17, ADPCM ROM byte-address width.
- SLOT_AW, 18, SDRAM slot byte-address width.
- PCM_OFFSET, 18'h08000, slot base address of the ADPCM region; the CPU region starts at 0.

Ports:
- clk  in  1  system clock, 24 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- cpu_cs  in  1  CPU ROM read request.
- cpu_addr  in  CPU_AW  CPU ROM address.
- cpu_data  out  8  CPU ROM data.
- cpu_ok  out  1  cpu_data is valid for cpu_addr.
- pcm_cs  in  1  ADPCM ROM read request.
- pcm_addr  in  PCM_AW  ADPCM ROM address.
- pcm_data  out  8  ADPCM ROM data.
- pcm_ok  out  1  pcm_data is valid for pcm_addr.
- slot_cs  out  1  SDRAM slot request.
- slot_addr  out  SLOT_AW  SDRAM slot address.
- slot_data  in  8  SDRAM slot read data.
- slot_ok  in  1  SDRAM slot data valid.
- busy  out  1  a slot transaction is outstanding.

Behaviour:
- Reset (asynchronous, rst_n low):
  - Outputs: slot_cs=0, slot_addr=0, busy=0, cpu_data=0, pcm_data=0, cpu_ok=0, pcm_ok=0.
  - Both cache tags are invalid.
  - State is IDLE and the round-robin pointer favours CPU.
- Cache entry, one per requester: valid flag, address tag, data byte.
- Hit, per requester: cs && valid && addr==tag.
  - ok = hit, decoded combinationally from the registered tag. A hit that existed in the previous cycle gives 0-cycle ok.
  - data is always the cached byte.
- State machine: IDLE, REQ, GAP.
  - IDLE:
    - Miss on exactly one requester → latch that requester's id and address, then go to REQ.
    - Misses on both → serve the requester not served last and flip the pointer.
    - slot_addr = cpu_addr zero-extended for the CPU, or PCM_OFFSET + pcm_addr (SLOT_AW-bit add, wraps) for the ADPCM.
  - REQ:
    - slot_cs=1 and busy=1; slot_addr stays stable.
    - slot_ok is ignored in the first REQ cycle (stale-ok guard).
    - From the second cycle on, the first slot_ok=1 writes slot_data and the latched address into the owner's entry, sets valid and goes to GAP.
  - GAP: one cycle with slot_cs=0 and busy=0, then back to IDLE.
  - Back-to-back misses therefore need at least 2 idle cycles between slot requests.
- Miss-to-ok latency: slot latency + 2 clk. ok rises the cycle after the tag write.
- Boundary conditions:
  - Address changes during REQ: the transaction completes and fills the old address; the new address misses and is re-requested after GAP.
  - cs drops during REQ: no abort; the fill completes.
  - A hit on the non-owner during REQ is served from its cache with no stall.
  - The owner's own entry keeps its old data until the fill; ok stays low because the tag differs.
  - slot_ok held high continuously: exactly one capture per REQ.
  - Reset during REQ: slot_cs drops immediately; the partial transaction is discarded and tags are invalid.

Optional Feature:
- JTCONTRA_SNDARB_CPUPRIO_EN defined: simultaneous misses always go to the CPU and the pointer is unused. This minimises Z80 wait states, at the cost of ADPCM starvation under heavy CPU misses.
- Undefined: round-robin as described.

Test Plan:
- Reset, then cpu_cs=1, cpu_addr=15'h0123, slot returns 8'hA5 with slot_ok 3 cycles after slot_cs → slot_addr=18'h00123, cpu_ok=1 and cpu_data=A5 two cycles later; a repeat read gives ok in the same cycle with no slot_cs.
- pcm_cs=1, pcm_addr=17'h1FFFF → slot_addr=18'h27FFF, and pcm_ok follows the fill.
- Both miss in the same cycle after reset → CPU served first, then PCM after the GAP cycle. Repeated simultaneous misses alternate CPU, PCM, CPU. With JTCONTRA_SNDARB_CPUPRIO_EN the CPU wins every time.
- slot_ok held high before and through slot_cs assertion → no capture in the first REQ cycle; capture happens in the second cycle, exactly once.
- cpu_addr changes from 0x10 to 0x11 mid-REQ → the tag fills with 0x10, cpu_ok stays 0, and a second slot request goes out for 0x11.
- rst_n pulsed low during REQ → slot_cs=0 immediately. After release a previously cached address misses and re-requests.
